avmm_rw_responder: RTL and testbench

//  Avalon-MM fixed-latency memory responder (agent) for an HLS component's avmm_0_rw master port.

---
 rtl/avmm_resp_pkg.sv | 34 +++
 rtl/avmm_resp_ram.sv | 35 +++
 rtl/avmm_rw_responder.sv | 139 +++++++++++++
 tb/tb_avmm_rw_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/avmm_resp_pkg.sv
// Shared widths, payload types and helpers for the Avalon-MM fixed-latency responder.
// The optional statistics counters are enabled by defining AVMM_RESP_STATS_EN.
package avmm_resp_pkg;

    localparam int unsigned AVMM_ADDR_W      = 64;
    localparam int unsigned AVMM_DATA_W      = 64;
    localparam int unsigned AVMM_BE_W        = 8;
    localparam int unsigned MAX_READ_LATENCY = 8;
    localparam int unsigned CNT_W            = 32;

    typedef logic [AVMM_DATA_W-1:0] word_t;
    typedef logic [AVMM_ADDR_W-1:0] addr_t;
    typedef logic [AVMM_BE_W-1:0]   be_t;
    typedef logic [CNT_W-1:0]       cnt_t;

    // One stage of the read-return pipe
    typedef struct packed {
        logic  valid;
        word_t data;
    } rd_beat_t;

    // Saturating increment for the access counters
    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Keep the latency inside the supported 1..MAX_READ_LATENCY range
    function automatic int unsigned clamp_latency(input int unsigned l);
        if (l < 1) return 1;
        if (l > MAX_READ_LATENCY) return MAX_READ_LATENCY;
        return l;
    endfunction

endpackage

// File: rtl/avmm_resp_ram.sv
// Single-port 64-bit RAM with per-byte write enables and a registered read port.
// A read and write to the same word in one cycle returns the pre-write contents.
module avmm_resp_ram
    import avmm_resp_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clock,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic                  i_re,
    input  logic [AVMM_BE_W-1:0]  i_we,
    input  logic [AVMM_DATA_W-1:0] i_wdata,
    output logic [AVMM_DATA_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    word_t r_mem [DEPTH];
    word_t r_rdata;

    // Storage is deliberately left unreset; only the lanes with a write enable change
    always_ff @(posedge clock) begin
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
        for (int b = 0; b < int'(AVMM_BE_W); b++) begin
            if (i_we[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/avmm_rw_responder.sv
// Avalon-MM fixed-latency memory agent: byte-enabled 64-bit reads/writes to on-chip RAM.
// Define AVMM_RESP_STATS_EN to add saturating rd_count/wr_count outputs.
module avmm_rw_responder
    import avmm_resp_pkg::*;
#(
    parameter int unsigned             DEPTH_LOG2   = 10,
    parameter int unsigned             READ_LATENCY = 1,
    parameter logic [AVMM_ADDR_W-1:0]  BASE_ADDR    = '0
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [AVMM_ADDR_W-1:0] avmm_0_rw_address,
    input  logic [AVMM_BE_W-1:0]   avmm_0_rw_byteenable,
    input  logic                   avmm_0_rw_read,
    input  logic                   avmm_0_rw_write,
    input  logic [AVMM_DATA_W-1:0] avmm_0_rw_writedata,
    output logic [AVMM_DATA_W-1:0] avmm_0_rw_readdata,
    output logic                   rd_valid,
    output logic                   range_err
`ifdef AVMM_RESP_STATS_EN
    ,
    output logic [31:0]            rd_count,
    output logic [31:0]            wr_count
`endif
);

    localparam int unsigned LAT       = clamp_latency(READ_LATENCY);
    localparam addr_t       WIN_BYTES = AVMM_ADDR_W'(1) << (DEPTH_LOG2 + 3);

    addr_t                 w_off;
    logic                  w_in_win;
    logic [DEPTH_LOG2-1:0] w_word;
    logic                  w_ram_re;
    be_t                   w_ram_we;
    word_t                 w_ram_rdata;
    logic                  w_err;
    rd_beat_t              w_s0;

    logic                  r_s0_valid;
    logic                  r_s0_hit;
    rd_beat_t              r_pipe [LAT];
    logic                  r_range_err;

    // Address decode; addresses below the base wrap to a huge offset and miss the window
    always_comb begin
        w_off    = avmm_0_rw_address - BASE_ADDR;
        w_in_win = (w_off < WIN_BYTES);
        w_word   = w_off[DEPTH_LOG2+2:3];
        w_ram_re = avmm_0_rw_read & w_in_win;
        w_ram_we = (avmm_0_rw_write & w_in_win) ? avmm_0_rw_byteenable : '0;
        w_err    = ((avmm_0_rw_read | avmm_0_rw_write) & ~w_in_win)
                 | (avmm_0_rw_read & avmm_0_rw_write);
    end

    avmm_resp_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clock   (clock),
        .i_addr  (w_word),
        .i_re    (w_ram_re),
        .i_we    (w_ram_we),
        .i_wdata (avmm_0_rw_writedata),
        .o_rdata (w_ram_rdata)
    );

    // Track which RAM output cycle carries a read, and whether it hit the window
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_s0_valid <= 1'b0;
            r_s0_hit   <= 1'b0;
        end else begin
            r_s0_valid <= avmm_0_rw_read;
            r_s0_hit   <= w_in_win;
        end
    end

    // Out-of-window reads return zero on the normal timeline
    always_comb begin
        w_s0.valid = r_s0_valid;
        w_s0.data  = r_s0_hit ? w_ram_rdata : '0;
    end

    // Latency shift; data only advances with a valid beat so the last stage holds between returns
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < int'(LAT); k++) begin
                r_pipe[k] <= '0;
            end
        end else begin
            r_pipe[0].valid <= w_s0.valid;
            if (w_s0.valid) begin
                r_pipe[0].data <= w_s0.data;
            end
            for (int k = 1; k < int'(LAT); k++) begin
                r_pipe[k].valid <= r_pipe[k-1].valid;
                if (r_pipe[k-1].valid) begin
                    r_pipe[k].data <= r_pipe[k-1].data;
                end
            end
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_range_err <= 1'b0;
        end else if (w_err) begin
            r_range_err <= 1'b1;
        end
    end

    assign avmm_0_rw_readdata = r_pipe[LAT-1].data;
    assign rd_valid           = r_pipe[LAT-1].valid;
    assign range_err          = r_range_err;

`ifdef AVMM_RESP_STATS_EN
    cnt_t r_rd_count;
    cnt_t r_wr_count;

    // Count every accepted strobe, in or out of the window
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (avmm_0_rw_read) begin
                r_rd_count <= sat_inc(r_rd_count);
            end
            if (avmm_0_rw_write) begin
                r_wr_count <= sat_inc(r_wr_count);
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_avmm_rw_responder.sv
// Directed bench for avmm_rw_responder (READ_LATENCY=3, 16-word window at base 0).
// With AVMM_RESP_STATS_EN defined the access counters are also checked.
module tb_avmm_rw_responder;
    import avmm_resp_pkg::*;

    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int unsigned LAT        = 3;

    localparam word_t D0      = 64'h1122_3344_5566_7788;
    localparam word_t D0_BE   = 64'h1122_3344_AAAA_AAAA;
    localparam word_t D1      = 64'hCAFE_F00D_DEAD_BEEF;
    localparam word_t D2      = 64'h0123_4567_89AB_CDEF;
    localparam word_t D3      = 64'h7766_5544_3322_1100;
    localparam word_t DLAST   = 64'hFEDC_BA98_7654_3210;
    localparam word_t DNEW    = 64'h0F0E_0D0C_0B0A_0908;

    logic  clock;
    logic  resetn;
    addr_t avmm_0_rw_address;
    be_t   avmm_0_rw_byteenable;
    logic  avmm_0_rw_read;
    logic  avmm_0_rw_write;
    word_t avmm_0_rw_writedata;
    word_t avmm_0_rw_readdata;
    logic  rd_valid;
    logic  range_err;
`ifdef AVMM_RESP_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    avmm_rw_responder #(
        .DEPTH_LOG2   (DEPTH_LOG2),
        .READ_LATENCY (LAT),
        .BASE_ADDR    (64'h0)
    ) dut (
        .clock                (clock),
        .resetn               (resetn),
        .avmm_0_rw_address    (avmm_0_rw_address),
        .avmm_0_rw_byteenable (avmm_0_rw_byteenable),
        .avmm_0_rw_read       (avmm_0_rw_read),
        .avmm_0_rw_write      (avmm_0_rw_write),
        .avmm_0_rw_writedata  (avmm_0_rw_writedata),
        .avmm_0_rw_readdata   (avmm_0_rw_readdata),
        .rd_valid             (rd_valid),
        .range_err            (range_err)
`ifdef AVMM_RESP_STATS_EN
        ,
        .rd_count             (rd_count),
        .wr_count             (wr_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_idle();
        avmm_0_rw_address    = '0;
        avmm_0_rw_byteenable = '0;
        avmm_0_rw_read       = 1'b0;
        avmm_0_rw_write      = 1'b0;
        avmm_0_rw_writedata  = '0;
    endtask

    task automatic bus_write(input addr_t a, input word_t d, input be_t be);
        avmm_0_rw_address    = a;
        avmm_0_rw_writedata  = d;
        avmm_0_rw_byteenable = be;
        avmm_0_rw_write      = 1'b1;
        step();
        bus_idle();
    endtask

    task automatic bus_read(input addr_t a);
        avmm_0_rw_address = a;
        avmm_0_rw_read    = 1'b1;
        step();
        bus_idle();
    endtask

    // Issue one read and return what the outputs show LAT edges later
    task automatic read_word(input addr_t a, output word_t d, output logic v);
        bus_read(a);
        repeat (LAT) step();
        d = avmm_0_rw_readdata;
        v = rd_valid;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic test_reset();
        bus_idle();
        resetn = 1'b0;
        step();
        step();
        n_vec++; if (avmm_0_rw_readdata !== 64'h0) begin n_err++; $display("FAIL reset_readdata: got %h want 0", avmm_0_rw_readdata); end
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_vec++; if (range_err !== 1'b0) begin n_err++; $display("FAIL reset_range_err: got %b want 0", range_err); end
`ifdef AVMM_RESP_STATS_EN
        n_vec++; if (rd_count !== 32'd0 || wr_count !== 32'd0) begin n_err++; $display("FAIL reset_counts: got %0d/%0d want 0/0", rd_count, wr_count); end
`endif
        resetn = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        bus_write(64'h0, D0, 8'hFF);
        bus_read(64'h0);
        step();
        step();
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL wr_rd_early_valid: got %b want 0", rd_valid); end
        step();
        n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL wr_rd_valid: got %b want 1", rd_valid); end
        n_vec++; if (avmm_0_rw_readdata !== D0) begin n_err++; $display("FAIL wr_rd_data: got %h want %h", avmm_0_rw_readdata, D0); end
        step();
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL wr_rd_valid_pulse: got %b want 0", rd_valid); end
        n_vec++; if (avmm_0_rw_readdata !== D0) begin n_err++; $display("FAIL wr_rd_hold: got %h want %h", avmm_0_rw_readdata, D0); end
        n_vec++; if (range_err !== 1'b0) begin n_err++; $display("FAIL wr_rd_no_err: got %b want 0", range_err); end
    endtask

    task automatic test_byteenable();
        word_t d;
        logic  v;
        bus_write(64'h0, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
        read_word(64'h0, d, v);
        n_vec++; if (v !== 1'b1 || d !== D0_BE) begin n_err++; $display("FAIL be_low_lanes: got v=%b %h want v=1 %h", v, d, D0_BE); end
        // Unaligned address lands on word 1
        bus_write(64'h0D, D1, 8'hFF);
        read_word(64'h08, d, v);
        n_vec++; if (d !== D1) begin n_err++; $display("FAIL unaligned_write: got %h want %h", d, D1); end
        bus_write(64'h10, D2, 8'hFF);
        // Last in-window word, accessed unaligned
        bus_write(64'h78, DLAST, 8'hFF);
        read_word(64'h7B, d, v);
        n_vec++; if (d !== DLAST) begin n_err++; $display("FAIL last_word: got %h want %h", d, DLAST); end
        n_vec++; if (range_err !== 1'b0) begin n_err++; $display("FAIL last_word_no_err: got %b want 0", range_err); end
    endtask

    task automatic test_back_to_back();
        avmm_0_rw_read    = 1'b1;
        avmm_0_rw_address = 64'h00; step();
        avmm_0_rw_address = 64'h08; step();
        avmm_0_rw_address = 64'h10; step();
        bus_idle();
        step();
        n_vec++; if (rd_valid !== 1'b1 || avmm_0_rw_readdata !== D0_BE) begin n_err++; $display("FAIL b2b_ret0: got v=%b %h want v=1 %h", rd_valid, avmm_0_rw_readdata, D0_BE); end
        step();
        n_vec++; if (rd_valid !== 1'b1 || avmm_0_rw_readdata !== D1) begin n_err++; $display("FAIL b2b_ret1: got v=%b %h want v=1 %h", rd_valid, avmm_0_rw_readdata, D1); end
        step();
        n_vec++; if (rd_valid !== 1'b1 || avmm_0_rw_readdata !== D2) begin n_err++; $display("FAIL b2b_ret2: got v=%b %h want v=1 %h", rd_valid, avmm_0_rw_readdata, D2); end
        step();
        n_vec++; if (rd_valid !== 1'b0 || avmm_0_rw_readdata !== D2) begin n_err++; $display("FAIL b2b_after: got v=%b %h want v=0 %h", rd_valid, avmm_0_rw_readdata, D2); end
    endtask

    task automatic test_out_of_window();
        word_t d;
        logic  v;
        read_word(64'h80, d, v);
        n_vec++; if (v !== 1'b1 || d !== 64'h0) begin n_err++; $display("FAIL oow_read: got v=%b %h want v=1 0", v, d); end
        n_vec++; if (range_err !== 1'b1) begin n_err++; $display("FAIL oow_read_err: got %b want 1", range_err); end
        // Would alias onto word 0 if not dropped
        bus_write(64'h80, 64'h5555_5555_5555_5555, 8'hFF);
        read_word(64'h0, d, v);
        n_vec++; if (d !== D0_BE) begin n_err++; $display("FAIL oow_write_dropped: got %h want %h", d, D0_BE); end
        repeat (5) step();
        n_vec++; if (range_err !== 1'b1) begin n_err++; $display("FAIL oow_err_sticky: got %b want 1", range_err); end
    endtask

    task automatic test_rw_same_cycle();
        word_t d;
        logic  v;
        do_reset();
        n_vec++; if (range_err !== 1'b0) begin n_err++; $display("FAIL rw_err_cleared: got %b want 0", range_err); end
        avmm_0_rw_address    = 64'h08;
        avmm_0_rw_writedata  = DNEW;
        avmm_0_rw_byteenable = 8'hFF;
        avmm_0_rw_read       = 1'b1;
        avmm_0_rw_write      = 1'b1;
        step();
        bus_idle();
        repeat (LAT) step();
        n_vec++; if (rd_valid !== 1'b1 || avmm_0_rw_readdata !== D1) begin n_err++; $display("FAIL rw_old_data: got v=%b %h want v=1 %h", rd_valid, avmm_0_rw_readdata, D1); end
        n_vec++; if (range_err !== 1'b1) begin n_err++; $display("FAIL rw_err: got %b want 1", range_err); end
        read_word(64'h08, d, v);
        n_vec++; if (d !== DNEW) begin n_err++; $display("FAIL rw_new_data: got %h want %h", d, DNEW); end
    endtask

    task automatic test_reset_in_flight();
        avmm_0_rw_read    = 1'b1;
        avmm_0_rw_address = 64'h00; step();
        avmm_0_rw_address = 64'h08; step();
        bus_idle();
        resetn = 1'b0;
        #1;
        n_vec++; if (rd_valid !== 1'b0 || avmm_0_rw_readdata !== 64'h0) begin n_err++; $display("FAIL flight_reset_out: got v=%b %h want v=0 0", rd_valid, avmm_0_rw_readdata); end
        step();
        step();
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL flight_ghost_%0d: got %b want 0", i, rd_valid); end
        end
        // Fresh traffic after reset: one write, three back-to-back reads
        bus_write(64'h18, D3, 8'hFF);
        avmm_0_rw_read    = 1'b1;
        avmm_0_rw_address = 64'h00; step();
        avmm_0_rw_address = 64'h08; step();
        avmm_0_rw_address = 64'h18; step();
        bus_idle();
        step();
        n_vec++; if (rd_valid !== 1'b1 || avmm_0_rw_readdata !== D0_BE) begin n_err++; $display("FAIL post_rst_ret0: got v=%b %h want v=1 %h", rd_valid, avmm_0_rw_readdata, D0_BE); end
        step();
        n_vec++; if (rd_valid !== 1'b1 || avmm_0_rw_readdata !== DNEW) begin n_err++; $display("FAIL post_rst_ret1: got v=%b %h want v=1 %h", rd_valid, avmm_0_rw_readdata, DNEW); end
        step();
        n_vec++; if (rd_valid !== 1'b1 || avmm_0_rw_readdata !== D3) begin n_err++; $display("FAIL post_rst_ret2: got v=%b %h want v=1 %h", rd_valid, avmm_0_rw_readdata, D3); end
        n_vec++; if (range_err !== 1'b0) begin n_err++; $display("FAIL post_rst_no_err: got %b want 0", range_err); end
`ifdef AVMM_RESP_STATS_EN
        n_vec++; if (rd_count !== 32'd3) begin n_err++; $display("FAIL stats_rd: got %0d want 3", rd_count); end
        n_vec++; if (wr_count !== 32'd1) begin n_err++; $display("FAIL stats_wr: got %0d want 1", wr_count); end
`endif
    endtask

    initial begin
        resetn = 1'b0;
        bus_idle();
        test_reset();
        test_write_read();
        test_byteenable();
        test_back_to_back();
        test_out_of_window();
        test_rw_same_cycle();
        test_reset_in_flight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Backstop against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
